// File: rtl/apb_master_module.sv
// APB initiator: turns single host commands into APB SETUP/ACCESS sequences and
// reports read data, slave error and timeout on a one-cycle response pulse.
module apb_master_module #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16,
  localparam int unsigned MAX_DIM   = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // Host command port
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [MAX_DIM-1:0]    cmd_strb_i,
  // APB requester port
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  // Response port
  output logic                  rsp_valid_o,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [MAX_DIM-1:0]    pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [BUS_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          state_d  = StSetup;
          cnt_d    = '0;
          psel_d   = 1'b1;
          pwrite_d = cmd_write_i;
          paddr_d  = cmd_addr_i;
          // Reads never carry data or strobes onto the bus.
          pwdata_d = cmd_write_i ? cmd_wdata_i : '0;
          pstrb_d  = cmd_write_i ? cmd_strb_i : '0;
        end
      end

      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end

      StAccess: begin
        if (pready_i || (cnt_q == CntW'(TIMEOUT - 1))) begin
          // A ready slave on the timeout edge still completes normally.
          state_d       = StIdle;
          cnt_d         = '0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          pwrite_d      = 1'b0;
          paddr_d       = '0;
          pwdata_d      = '0;
          pstrb_d       = '0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = !pready_i;
          rsp_err_d     = pready_i ? pslverr_i : 1'b1;
          rsp_rdata_d   = (pready_i && !pwrite_q) ? prdata_i : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready_o   = (state_q == StIdle);
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_module.sv
// Directed plus randomized bench for apb_master_module; a transfer-level model predicts
// bus phases and the response from the command, slave wait count and slave answer.
module tb_apb_master_module;

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;
  localparam int unsigned MD = BW / DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [BW-1:0] cmd_wdata = '0;
  logic [MD-1:0] cmd_strb = '0;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [BW-1:0] pwdata;
  logic [MD-1:0] pstrb;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;
  logic [BW-1:0] prdata = '0;
  logic          rsp_valid;
  logic [BW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;

  int total = 0;
  int bad = 0;

  // Last response the model expects the DUT to be holding.
  logic [BW-1:0] exp_rdata = '0;
  logic          exp_err = 1'b0;
  logic          exp_tmo = 1'b0;

  apb_master_module #(
    .DATA_WIDTH(DW),
    .BUS_WIDTH (BW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_write_i  (cmd_write),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_strb_i   (cmd_strb),
    .psel_o       (psel),
    .penable_o    (penable),
    .pwrite_o     (pwrite),
    .paddr_o      (paddr),
    .pwdata_o     (pwdata),
    .pstrb_o      (pstrb),
    .pready_i     (pready),
    .pslverr_i    (pslverr),
    .prdata_i     (prdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string ph, input logic sel, input logic en, input logic wr,
                         input logic [AW-1:0] a, input logic [BW-1:0] wd,
                         input logic [MD-1:0] st);
    chk({ph, ".psel"}, 64'(psel), 64'(sel));
    chk({ph, ".penable"}, 64'(penable), 64'(en));
    chk({ph, ".pwrite"}, 64'(pwrite), 64'(wr));
    chk({ph, ".paddr"}, 64'(paddr), 64'(a));
    chk({ph, ".pwdata"}, 64'(pwdata), 64'(wd));
    chk({ph, ".pstrb"}, 64'(pstrb), 64'(st));
  endtask

  task automatic chk_rsp(input string ph, input logic v);
    chk({ph, ".rsp_valid"}, 64'(rsp_valid), 64'(v));
    chk({ph, ".rsp_rdata"}, 64'(rsp_rdata), exp_rdata);
    chk({ph, ".rsp_err"}, 64'(rsp_err), 64'(exp_err));
    chk({ph, ".rsp_timeout"}, 64'(rsp_timeout), 64'(exp_tmo));
  endtask

  task automatic scramble_cmd();
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = {$urandom, $urandom};
    cmd_strb  = MD'($urandom);
  endtask

  // Called on a negedge with the master idle; returns on the negedge of the response
  // cycle. With hold set, cmd_valid stays high so the caller must chain another transfer.
  task automatic do_xfer(input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] wd,
                         input logic [MD-1:0] st, input int waits, input bit slverr,
                         input logic [BW-1:0] rd, input bit hold);
    logic [BW-1:0] e_wd;
    logic [MD-1:0] e_st;
    bit            tmo;
    int            n_access;
    e_wd     = wr ? wd : '0;
    e_st     = wr ? st : '0;
    tmo      = (waits >= int'(TO));
    n_access = tmo ? int'(TO) : waits + 1;

    chk("accept.cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_strb  = st;
    pready    = 1'b0;
    @(negedge clk);
    cmd_valid = hold;
    scramble_cmd();
    chk_bus("setup", 1'b1, 1'b0, wr, a, e_wd, e_st);
    chk("setup.cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    for (int i = 0; i < n_access; i++) begin
      chk_bus("access", 1'b1, 1'b1, wr, a, e_wd, e_st);
      chk("access.cmd_ready", 64'(cmd_ready), 64'd0);
      chk("access.rsp_valid", 64'(rsp_valid), 64'd0);
      pready  = (i == waits);
      pslverr = (i == waits) ? slverr : 1'($urandom);
      prdata  = (i == waits) ? rd : {$urandom, $urandom};
      scramble_cmd();
      @(negedge clk);
    end
    pready    = 1'b0;
    pslverr   = 1'b0;
    exp_tmo   = tmo;
    exp_err   = tmo | slverr;
    exp_rdata = (!tmo && !wr) ? rd : '0;
    chk_rsp("done", 1'b1);
    chk_bus("done", 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic idle_check();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk_rsp("idle", 1'b0);
    chk_bus("idle", 1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("idle.cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    // Reset state
    #1;
    chk("reset.cmd_ready", 64'(cmd_ready), 64'd1);
    chk_rsp("reset", 1'b0);
    chk_bus("reset", 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check();

    // Zero-wait write
    do_xfer(1'b1, 32'h04, 64'h0000_0002_0000_0001, 2'b11, 0, 1'b0, 64'h0, 1'b0);
    idle_check();

    // Read with three wait cycles; strobes must not reach the bus
    do_xfer(1'b0, 32'h08, 64'h1111_2222_3333_4444, 2'b11, 3, 1'b0,
            64'hDEAD_BEEF_0123_4567, 1'b0);
    idle_check();

    // Slave error on a write
    do_xfer(1'b1, 32'h0C, 64'h5, 2'b01, 1, 1'b1, 64'h0, 1'b0);
    idle_check();

    // Timeout on write and on read, then ready exactly on the last allowed edge
    do_xfer(1'b1, 32'h10, 64'h77, 2'b10, TO, 1'b0, 64'h0, 1'b0);
    idle_check();
    do_xfer(1'b0, 32'h14, 64'h0, 2'b00, TO + 3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    idle_check();
    do_xfer(1'b0, 32'h18, 64'h0, 2'b00, TO - 1, 1'b0, 64'hCAFE_F00D_1234_5678, 1'b0);
    idle_check();

    // Back-to-back with cmd_valid held high across the first transfer
    do_xfer(1'b1, 32'h20, 64'hA5A5_A5A5_5A5A_5A5A, 2'b11, 0, 1'b0, 64'h0, 1'b1);
    do_xfer(1'b0, 32'h24, 64'h0, 2'b01, 0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);
    idle_check();

    // Randomized transfers, sometimes chained, sometimes with idle gaps
    for (int n = 0; n < 30; n++) begin
      do_xfer(1'($urandom), $urandom, {$urandom, $urandom}, MD'($urandom),
              int'($urandom_range(0, TO + 1)), 1'($urandom), {$urandom, $urandom}, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    // Asynchronous reset in the middle of a stalled ACCESS phase
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h30;
    cmd_wdata = 64'h99;
    cmd_strb  = 2'b11;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("prereset.penable", 64'(penable), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_rdata = '0;
    exp_err   = 1'b0;
    exp_tmo   = 1'b0;
    chk_bus("midreset", 1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("midreset.cmd_ready", 64'(cmd_ready), 64'd1);
    chk_rsp("midreset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check();
    idle_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_module.md
# apb_master_module

APB initiator that turns single-transfer commands from a host-side command port into APB setup/access sequences toward the matmul register slave. It is the requester counterpart of the design's APB slave: it drives select, enable, write, address, write data and strobe, then returns read data, slave error and timeout status on a one-cycle response pulse. It sits between the host/testbench driver and the slave, one outstanding transfer at a time.

## Interface
- DATA_WIDTH, 32, element width; one strobe bit per element
- BUS_WIDTH, 64, APB data bus width
- ADDR_WIDTH, 32, APB address width
- TIMEOUT, 16, max ACCESS cycles waiting for pready_i (must be ≥1)
- Derived: MAX_DIM = BUS_WIDTH/DATA_WIDTH (strobe width)
- clk_i  in  1  clock, all flops on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  master can accept a command (high iff state IDLE)
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_WIDTH  target address
- cmd_wdata_i  in  BUS_WIDTH  write data
- cmd_strb_i  in  MAX_DIM  write strobes
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- paddr_o  out  ADDR_WIDTH  APB address
- pwdata_o  out  BUS_WIDTH  APB write data
- pstrb_o  out  MAX_DIM  APB strobes
- pready_i  in  1  slave ready
- pslverr_i  in  1  slave error, valid only with pready_i
- prdata_i  in  BUS_WIDTH  slave read data, valid only with pready_i
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  BUS_WIDTH  read data of completed read (0 for writes/timeouts)
- rsp_err_o  out  1  completion had pslverr_i or timeout
- rsp_timeout_o  out  1  completion was a timeout

## Operation
- States: IDLE, SETUP, ACCESS; reset state IDLE.
- IDLE: cmd_ready_o=1; psel_o/penable_o=0; paddr_o/pwdata_o/pstrb_o/pwrite_o driven 0. Edge with cmd_valid_i=1 → latch command, go SETUP.
- SETUP: psel_o=1, penable_o=0, paddr_o/pwrite_o/pwdata_o/pstrb_o from latched command; next edge → ACCESS unconditionally.
- Reads: pstrb_o=0 and pwdata_o=0 for the whole transfer regardless of cmd_strb_i/cmd_wdata_i.
- ACCESS: psel_o=1, penable_o=1, all APB outputs held stable. Timeout counter counts ACCESS edges with pready_i=0.
  - Edge with pready_i=1 → IDLE; rsp_valid_o=1 next cycle; rsp_err_o=pslverr_i; rsp_rdata_o=prdata_i for reads, 0 for writes; rsp_timeout_o=0.
  - TIMEOUT-th ACCESS edge with pready_i still 0 → IDLE; rsp_valid_o=1, rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
  - pready_i=1 on the timeout edge: normal completion wins.
- psel_o never drops before completion or timeout; no back-to-back transfer without passing through IDLE.
- rsp_rdata_o/rsp_err_o/rsp_timeout_o update only at completion and hold until the next completion.
- cmd_* inputs ignored outside IDLE.

## Timing
- Reset (async, any state): state IDLE, counter 0, all registered outputs 0; cmd_ready_o=1. In-flight transfer dropped, no response pulse.
- Command accepted at edge k: SETUP during cycle k+1, ACCESS from k+2.
- Zero-wait slave (pready_i=1 in first ACCESS cycle): rsp_valid_o high in cycle k+3; cmd_ready_o high in k+3; next command acceptable at edge k+3 → 3-cycle throughput.
- Each wait cycle adds one cycle to latency.
- rsp_valid_o is exactly one cycle wide.
- All APB and response outputs are registered; cmd_ready_o is decoded from state.

## Test plan
- Reset mid-ACCESS (pready_i=0): psel_o/penable_o/paddr_o fall to 0 immediately, no rsp_valid_o, cmd_ready_o=1 after release.
- Write addr 0x04, wdata 0x0000_0002_0000_0001, strb 2'b11, zero-wait slave: psel_o 1 for cycles k+1..k+2, penable_o only in k+2, pstrb_o=2'b11; rsp_valid_o in k+3 with rsp_err_o=0, rsp_rdata_o=0.
- Read addr 0x08 with cmd_strb_i=2'b11, slave returns 0xDEAD_BEEF_0123_4567 after 3 wait cycles: pstrb_o=0 throughout, penable_o high 4 cycles, rsp_rdata_o=0xDEAD_BEEF_0123_4567, rsp_err_o=0.
- Write addr 0x0C (flags register), slave answers pready_i=1, pslverr_i=1: rsp_err_o=1, rsp_timeout_o=0.
- TIMEOUT=4, pready_i held 0: exactly 4 ACCESS cycles, then rsp_valid_o=1, rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0; repeat with pready_i=1 on 4th edge → normal completion, rsp_timeout_o=0.
- Two commands with cmd_valid_i held high: second accepted in the cycle rsp_valid_o of the first is high; cmd_* changes during a transfer do not alter paddr_o/pwdata_o.
